// File: rtl/effect_tremolo_pkg.sv
// Shared constants and helpers for the tremolo effect stage.
package effect_tremolo_pkg;

    localparam int          SAMPLE_RATE = 32000;
    localparam int          PHASE_W     = 32;
    localparam int          TRI_W       = 15;
    localparam int          DATA_W      = 16;
    localparam logic [31:0] INC_PER_HZ  = 32'd134218;
    localparam logic [15:0] GAIN_OFFSET = 16'd16384;

    // Phase increment per sample for a rate of (freq+1) Hz at SAMPLE_RATE.
    function automatic logic [PHASE_W-1:0] inc_for(input logic [2:0] freq);
        logic [PHASE_W-1:0] hz;
        hz = {29'd0, freq} + 32'd1;
        return hz * INC_PER_HZ;
    endfunction

endpackage

// File: rtl/tremolo_lfo.sv
// Triangle LFO: 32-bit phase accumulator folded into a 15-bit triangle.
module tremolo_lfo
    import effect_tremolo_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             clear,
    input  logic [2:0]       freq,
    output logic [TRI_W-1:0] tri_out
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;
    logic [15:0]        unused_phase_lsbs;

    // Next phase: clear wins over step so bypass always restarts at gain 0.5.
    always_comb begin
        phase_d = phase_q;
        if (clear) begin
            phase_d = '0;
        end else if (step) begin
            phase_d = phase_q + inc_for(freq);
        end
    end

    // Phase register, wraps naturally modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Fold the upper phase bits: rise in the first half, fall in the second.
    always_comb begin
        if (phase_q[31]) begin
            tri_out = ~phase_q[30:16];
        end else begin
            tri_out = phase_q[30:16];
        end
    end

    assign unused_phase_lsbs = phase_q[15:0];

endmodule

// File: rtl/effect_tremolo.sv
// Tremolo stage: scales samples by a triangle-LFO gain in 0.5..~1.0, or bypasses.
module effect_tremolo
    import effect_tremolo_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clk_tri,
    input  logic              i_valid,
    input  logic              i_enable,
    input  logic [2:0]        i_freq,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [TRI_W-1:0]  tri_data_w;
    logic [15:0]       gain_w;
    logic signed [31:0] prod_w;
    logic [DATA_W-1:0] scaled_w;
    logic              lfo_step_w;
    logic              lfo_clear_w;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic              valid_q;
    logic              valid_d;
    logic [16:0]       unused_bits_w;

    assign lfo_step_w  = i_valid & i_enable;
    assign lfo_clear_w = i_valid & ~i_enable;

    tremolo_lfo u_lfo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .step    (lfo_step_w),
        .clear   (lfo_clear_w),
        .freq    (i_freq),
        .tri_out (tri_data_w)
    );

    // Gain in Q1.15 and the floor-shifted product; bit 15 of gain is always 0,
    // so treating it as signed keeps it positive.
    always_comb begin
        gain_w   = GAIN_OFFSET + {2'b00, tri_data_w[TRI_W-1:1]};
        prod_w   = $signed(i_data) * $signed(gain_w);
        scaled_w = prod_w[30:15];
    end

    // Output select: modulated or bypassed sample on valid, hold otherwise.
    always_comb begin
        data_d  = data_q;
        valid_d = i_valid;
        if (i_valid) begin
            if (i_enable) begin
                data_d = scaled_w;
            end else begin
                data_d = i_data;
            end
        end
    end

    // Output registers give the single cycle of latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

    assign unused_bits_w = {i_clk_tri, prod_w[31], prod_w[14:0]};

endmodule

// File: tb/tb_effect_tremolo.sv
// Directed bench for the tremolo stage with immediate-assertion checks.
module tb_effect_tremolo;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_enable;
    logic [2:0]  i_freq;
    logic [15:0] i_data;
    logic [15:0] o_data;
    logic        o_valid;

    int checks;
    int errors;

    effect_tremolo dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clk_tri (i_clk),
        .i_valid   (i_valid),
        .i_enable  (i_enable),
        .i_freq    (i_freq),
        .i_data    (i_data),
        .o_data    (o_data),
        .o_valid   (o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one cycle of inputs, let the edge capture them, sample 1 time unit later.
    task automatic applyStimulus(input logic valid, input logic enable,
                                 input logic [2:0] freq, input int data);
        i_valid  = valid;
        i_enable = enable;
        i_freq   = freq;
        i_data   = 16'(data);
        @(posedge i_clk);
        #1;
    endtask

    // Compare observed against expected, count it, report on mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        int d;
        int o;
        int ad;
        int ao;
        checks   = 0;
        errors   = 0;
        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_enable = 1'b0;
        i_freq   = 3'd0;
        i_data   = 16'd0;

        // Reset state
        #2;
        checkOutput("reset_o_data", int'($signed(o_data)), 0);
        checkOutput("reset_o_valid", int'(o_valid), 0);
        checkOutput("reset_tri", int'(dut.tri_data_w), 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // First enabled sample at gain 16384
        applyStimulus(1'b1, 1'b1, 3'd2, 1000);
        checkOutput("first_o_data", int'($signed(o_data)), 500);
        checkOutput("first_o_valid", int'(o_valid), 1);
        checkOutput("first_tri_after", int'(dut.tri_data_w), 6);

        // Bypass passes data and clears phase
        applyStimulus(1'b1, 1'b0, 3'd2, -1234);
        checkOutput("bypass_o_data", int'($signed(o_data)), -1234);
        checkOutput("bypass_o_valid", int'(o_valid), 1);
        checkOutput("bypass_tri", int'(dut.tri_data_w), 0);

        // Valid 1,0,1 with positive full-scale at low gain
        applyStimulus(1'b1, 1'b1, 3'd2, 32767);
        checkOutput("pos_full_o_data", int'($signed(o_data)), 16383);
        checkOutput("gap_tri_before", int'(dut.tri_data_w), 6);
        applyStimulus(1'b0, 1'b1, 3'd2, 5555);
        checkOutput("gap_o_valid", int'(o_valid), 0);
        checkOutput("gap_o_data_hold", int'($signed(o_data)), 16383);
        checkOutput("gap_tri_hold", int'(dut.tri_data_w), 6);
        applyStimulus(1'b1, 1'b1, 3'd2, 32767);
        checkOutput("resume_o_valid", int'(o_valid), 1);
        checkOutput("resume_o_data", int'($signed(o_data)), 16386);
        checkOutput("resume_tri_two_steps", int'(dut.tri_data_w), 12);

        // Clear phase, then one full 4000-sample period at 8 Hz with a ramp
        applyStimulus(1'b1, 1'b0, 3'd7, 0);
        checkOutput("clear_tri", int'(dut.tri_data_w), 0);
        for (int n = 0; n < 4000; n++) begin
            if (n == 2000) begin
                checkOutput("peak_tri", int'(dut.tri_data_w), 32767);
                d = -32768;
            end else begin
                d = n * 16 - 32768;
            end
            applyStimulus(1'b1, 1'b1, 3'd7, d);
            o  = int'($signed(o_data));
            ad = (d < 0) ? -d : d;
            ao = (o < 0) ? -o : o;
            if (n == 2000) begin
                checkOutput("peak_neg_full_o_data", o, -32767);
            end else begin
                checkOutput("ramp_bounds", int'((ao <= ad) && (2 * ao >= ad - 1)), 1);
            end
        end
        checkOutput("period_end_tri", int'(dut.tri_data_w), 0);

        // Mid-stream asynchronous reset
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b1, 1'b1, 3'd7, 20000);
        end
        checkOutput("pre_reset_o_valid", int'(o_valid), 1);
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_o_data", int'($signed(o_data)), 0);
        checkOutput("midrst_o_valid", int'(o_valid), 0);
        checkOutput("midrst_phase", int'(dut.u_lfo.phase_q), 0);
        @(posedge i_clk);
        #1;
        checkOutput("midrst_held_o_data", int'($signed(o_data)), 0);
        checkOutput("midrst_held_tri", int'(dut.tri_data_w), 0);
        i_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 3'd7, 32767);
        checkOutput("post_reset_o_data", int'($signed(o_data)), 16383);
        checkOutput("post_reset_o_valid", int'(o_valid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
